count_seq_checker: RTL and testbench

- Downstream monitor for the free-running up counter.
- Samples the counter's count value and checks that each sample is the previous value plus 1, modulo 2^WIDTH.
- Reports lock status, wrap events, counter restarts and sequence errors to a status or debug register block.
- Purely observational: it never drives the counter.

---
 rtl/count_mon_pkg.sv | 13 +
 rtl/sat_counter.sv | 34 +++
 rtl/count_seq_checker.sv | 163 ++++++++++++++++
 tb/tb_count_seq_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and default sizes for the count sequence monitor.
package count_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH  = 4;
  localparam int DEFAULT_STAT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating statistic counter; an increment in the same cycle as clr yields 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      if (clr)                   count_d = W'(1);
      else if (count_q != MAX_VAL) count_d = count_q + W'(1);
    end else if (clr) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/count_seq_checker.sv
// Passive monitor checking that sampled counts advance by one modulo 2^WIDTH.
// Define COUNT_SEQ_CHECKER_CAPTURE_EN to add cap_exp/cap_act error capture outputs.
module count_seq_checker
  import count_mon_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int STAT_W   = DEFAULT_STAT_W,
  parameter int LOCK_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              clear,
  output logic              locked,
  output logic              wrap_pulse,
  output logic              restart_pulse,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
  ,
  output logic [WIDTH-1:0]  cap_exp,
  output logic [WIDTH-1:0]  cap_act
`endif
);

  localparam logic [WIDTH-1:0] MAX_CNT  = {WIDTH{1'b1}};
  localparam logic [3:0]       LOCK_CNT = 4'(LOCK_LEN);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [3:0]         good_q, good_d;
  logic               locked_q, locked_d;
  logic               wrap_q, wrap_d;
  logic               restart_q, restart_d;
  logic               err_q, err_d;
  logic               sticky_q, sticky_d;
  logic [WIDTH-1:0]   exp_val;
  logic [3:0]         good_inc;

  assign exp_val  = prev_q + WIDTH'(1);
  assign good_inc = good_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    good_d    = good_q;
    wrap_d    = 1'b0;
    restart_d = 1'b0;
    err_d     = 1'b0;
    if (sample_en) begin
      prev_d = count_in;
      case (state_q)
        IDLE: begin
          state_d = ACQ;
          good_d  = '0;
        end
        ACQ: begin
          if (count_in == exp_val) begin
            good_d = good_inc;
            if (good_inc == LOCK_CNT) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (count_in == exp_val) begin
            wrap_d = (prev_q == MAX_CNT);
          end else begin
            // A jump to zero is the counter being reset, not a fault.
            restart_d = (count_in == '0);
            err_d     = (count_in != '0);
            state_d   = ACQ;
            good_d    = '0;
          end
        end
        default: begin
          state_d = IDLE;
          good_d  = '0;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
    sticky_d = err_d ? 1'b1 : (clear ? 1'b0 : sticky_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      good_q    <= '0;
      locked_q  <= 1'b0;
      wrap_q    <= 1'b0;
      restart_q <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      wrap_q    <= wrap_d;
      restart_q <= restart_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
    end
  end

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_d),
    .clr   (clear),
    .count (err_count)
  );

  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wrap_d),
    .clr   (clear),
    .count (wrap_count)
  );

  assign locked        = locked_q;
  assign wrap_pulse    = wrap_q;
  assign restart_pulse = restart_q;
  assign err_pulse     = err_q;
  assign err_sticky    = sticky_q;

`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] cap_exp_q, cap_exp_d;
  logic [WIDTH-1:0] cap_act_q, cap_act_d;

  always_comb begin
    cap_exp_d = cap_exp_q;
    cap_act_d = cap_act_q;
    if (err_d) begin
      cap_exp_d = exp_val;
      cap_act_d = count_in;
    end else if (clear) begin
      cap_exp_d = '0;
      cap_act_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_exp_q <= '0;
      cap_act_q <= '0;
    end else begin
      cap_exp_q <= cap_exp_d;
      cap_act_q <= cap_act_d;
    end
  end

  assign cap_exp = cap_exp_q;
  assign cap_act = cap_act_q;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker with a behavioural model feeding a scoreboard queue.
module tb_count_seq_checker;

  localparam int M_IDLE   = 0;
  localparam int M_ACQ    = 1;
  localparam int M_LOCKED = 2;
  localparam int TB_LOCK  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_en = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic       clear = 1'b0;
  logic       locked, wrap_pulse, restart_pulse, err_pulse, err_sticky;
  logic [7:0] err_count, wrap_count;
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
  logic [3:0] cap_exp, cap_act;
`endif

  int compared   = 0;
  int mismatched = 0;
  int step_no    = 0;

  typedef struct {
    logic       locked;
    logic       wrap;
    logic       restart;
    logic       err;
    logic       sticky;
    logic [7:0] errc;
    logic [7:0] wrapc;
    logic [3:0] cexp;
    logic [3:0] cact;
  } exp_t;

  exp_t sb[$];

  int         m_state = M_IDLE;
  logic [3:0] m_prev  = 4'd0;
  int         m_good  = 0;
  logic       m_sticky = 1'b0;
  int         m_errc  = 0;
  int         m_wrapc = 0;
  logic [3:0] m_cexp  = 4'd0;
  logic [3:0] m_cact  = 4'd0;

  count_seq_checker #(.WIDTH(4), .STAT_W(8), .LOCK_LEN(TB_LOCK)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_en     (sample_en),
    .count_in      (count_in),
    .clear         (clear),
    .locked        (locked),
    .wrap_pulse    (wrap_pulse),
    .restart_pulse (restart_pulse),
    .err_pulse     (err_pulse),
    .err_sticky    (err_sticky),
    .err_count     (err_count),
    .wrap_count    (wrap_count)
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    ,
    .cap_exp       (cap_exp),
    .cap_act       (cap_act)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_prev = 4'd0; m_good = 0; m_sticky = 1'b0;
    m_errc = 0; m_wrapc = 0; m_cexp = 4'd0; m_cact = 4'd0;
  endtask

  // Predicts outputs after the coming clock edge and queues them.
  task automatic model_step(input logic en, input logic [3:0] v, input logic clr);
    exp_t e;
    logic [3:0] ex;
    logic w, r, er;
    w = 1'b0; r = 1'b0; er = 1'b0;
    ex = m_prev + 4'd1;
    if (en) begin
      if (m_state == M_IDLE) begin
        m_state = M_ACQ; m_good = 0;
      end else if (m_state == M_ACQ) begin
        if (v == ex) begin
          m_good++;
          if (m_good == TB_LOCK) m_state = M_LOCKED;
        end else m_good = 0;
      end else begin
        if (v == ex) w = (m_prev == 4'hF);
        else begin
          if (v == 4'd0) r = 1'b1; else er = 1'b1;
          m_state = M_ACQ; m_good = 0;
        end
      end
      m_prev = v;
    end
    if (er) begin
      m_sticky = 1'b1;
      m_errc = clr ? 1 : ((m_errc == 255) ? 255 : m_errc + 1);
      m_cexp = ex; m_cact = v;
    end else if (clr) begin
      m_sticky = 1'b0; m_errc = 0; m_cexp = 4'd0; m_cact = 4'd0;
    end
    if (w) m_wrapc = clr ? 1 : ((m_wrapc == 255) ? 255 : m_wrapc + 1);
    else if (clr) m_wrapc = 0;
    e.locked = (m_state == M_LOCKED); e.wrap = w; e.restart = r; e.err = er;
    e.sticky = m_sticky; e.errc = 8'(m_errc); e.wrapc = 8'(m_wrapc);
    e.cexp = m_cexp; e.cact = m_cact;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("locked",        32'(locked),        32'(e.locked));
    chk("wrap_pulse",    32'(wrap_pulse),    32'(e.wrap));
    chk("restart_pulse", 32'(restart_pulse), 32'(e.restart));
    chk("err_pulse",     32'(err_pulse),     32'(e.err));
    chk("err_sticky",    32'(err_sticky),    32'(e.sticky));
    chk("err_count",     32'(err_count),     32'(e.errc));
    chk("wrap_count",    32'(wrap_count),    32'(e.wrapc));
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    chk("cap_exp",       32'(cap_exp),       32'(e.cexp));
    chk("cap_act",       32'(cap_act),       32'(e.cact));
`endif
  endtask

  task automatic step(input logic en, input logic [3:0] v, input logic clr);
    @(negedge clk);
    sample_en = en; count_in = v; clear = clr;
    model_step(en, v, clr);
    @(posedge clk);
    #1;
    step_no++;
    $display("step %0d en=%0b in=%0h clr=%0b -> lk=%0b wr=%0b rs=%0b er=%0b st=%0b ec=%0d wc=%0d",
             step_no, en, v, clr, locked, wrap_pulse, restart_pulse, err_pulse, err_sticky,
             err_count, wrap_count);
    check_pop();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"},  32'(locked),        32'd0);
    chk({tag, "_wrap"},    32'(wrap_pulse),    32'd0);
    chk({tag, "_restart"}, 32'(restart_pulse), 32'd0);
    chk({tag, "_err"},     32'(err_pulse),     32'd0);
    chk({tag, "_sticky"},  32'(err_sticky),    32'd0);
    chk({tag, "_errc"},    32'(err_count),     32'd0);
    chk({tag, "_wrapc"},   32'(wrap_count),    32'd0);
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    chk({tag, "_cexp"},    32'(cap_exp),       32'd0);
    chk({tag, "_cact"},    32'(cap_act),       32'd0);
`endif
  endtask

  initial begin
    logic [3:0] bad;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Acquire lock on 0,1,2.
    step(1'b1, 4'd0, 1'b0);
    step(1'b1, 4'd1, 1'b0);
    chk("t1_not_yet_locked", 32'(locked), 32'd0);
    step(1'b1, 4'd2, 1'b0);
    chk("t1_locked", 32'(locked), 32'd1);

    // Run up through 14,15,0 for a wrap.
    for (int i = 3; i <= 15; i++) step(1'b1, 4'(i), 1'b0);
    step(1'b1, 4'd0, 1'b0);
    chk("t2_wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("t2_wrap_count", 32'(wrap_count), 32'd1);
    chk("t2_err_count",  32'(err_count),  32'd0);

    // Locked at 5, jump to 9, then relock on 10,11.
    for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 1'b0);
    step(1'b1, 4'd9, 1'b0);
    chk("t3_err_pulse", 32'(err_pulse),  32'd1);
    chk("t3_err_count", 32'(err_count),  32'd1);
    chk("t3_unlocked",  32'(locked),     32'd0);
    step(1'b1, 4'd10, 1'b0);
    step(1'b1, 4'd11, 1'b0);
    chk("t3_relocked", 32'(locked),     32'd1);
    chk("t3_sticky",   32'(err_sticky), 32'd1);

    // Locked at 7, restart to 0, relock on 1,2.
    for (int i = 12; i <= 15; i++) step(1'b1, 4'(i), 1'b0);
    for (int i = 0; i <= 7; i++) step(1'b1, 4'(i), 1'b0);
    step(1'b1, 4'd0, 1'b0);
    chk("t4_restart",   32'(restart_pulse), 32'd1);
    chk("t4_err_count", 32'(err_count),     32'd1);
    chk("t4_unlocked",  32'(locked),        32'd0);
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    chk("t4_relocked", 32'(locked), 32'd1);

    // Clear alone drops statistics and sticky but keeps lock.
    step(1'b0, 4'd0, 1'b1);
    chk("clr_sticky", 32'(err_sticky), 32'd0);
    chk("clr_locked", 32'(locked),     32'd1);

    // 256 errors saturate err_count, each followed by a relock.
    for (int k = 0; k < 256; k++) begin
      bad = m_prev + 4'd5;
      if (bad == 4'd0) bad = 4'd1;
      step(1'b1, bad, 1'b0);
      step(1'b1, bad + 4'd1, 1'b0);
      step(1'b1, bad + 4'd2, 1'b0);
    end
    chk("t5_saturated", 32'(err_count), 32'd255);
    bad = m_prev + 4'd5;
    if (bad == 4'd0) bad = 4'd1;
    step(1'b1, bad, 1'b1);
    chk("t5_clear_err_count",  32'(err_count),  32'd1);
    chk("t5_clear_err_sticky", 32'(err_sticky), 32'd1);

    // Relock, pause sampling between 3 and 4.
    for (int i = 0; i <= 3; i++) step(1'b1, 4'(i), 1'b0);
    repeat (5) step(1'b0, 4'd9, 1'b0);
    step(1'b1, 4'd4, 1'b0);
    chk("t6_locked", 32'(locked),    32'd1);
    chk("t6_no_err", 32'(err_pulse), 32'd0);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 4'd5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
